beta_muldiv: RTL and testbench



---
 rtl/beta_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/beta_muldiv.sv | 158 +++++++++++++++
 tb/tb_beta_muldiv.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared encodings for the Beta multiply/divide unit: opcodes driven by decode
// and the iterative unit's FSM states.
package beta_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MOD  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_DIV) || (o == OP_MOD);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational bit-step shared by multiply (shift, add-or-pass) and
// restoring divide (shift, compare, subtract-or-restore).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_mul,
    input  logic [WIDTH-1:0] acc_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             qbit_o
);

    logic [WIDTH:0] trial;

    always_comb begin
        trial  = {acc_i, bit_i};
        acc_o  = trial[WIDTH-1:0];
        qbit_o = 1'b0;
        if (is_mul) begin
            acc_o = {acc_i[WIDTH-2:0], 1'b0} + (bit_i ? opnd_i : '0);
        end else if (trial >= {1'b0, opnd_i}) begin
            // Remainder stays below the divisor, so the true difference fits WIDTH bits.
            acc_o  = trial[WIDTH-1:0] - opnd_i;
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/beta_muldiv.sv
// Iterative multiply/divide unit for the pipelined Beta: start/busy/done handshake,
// fixed N+2 latency, UNROLL bits retired per RUN cycle.
module beta_muldiv
    import beta_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0,
    output logic             ovf
);

    localparam int N     = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH < 4) || (WIDTH % 2 != 0) || (WIDTH % UNROLL != 0) ||
        !((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4) || (UNROLL == 8))) begin : g_bad_cfg
        $error("beta_muldiv: illegal WIDTH/UNROLL combination");
    end

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q, div0_q, ovf_q;
    logic [WIDTH-1:0] result_q;

    op_e              op_q;
    logic [WIDTH-1:0] acc_q, sh_q, opnd_q;
    logic             qneg_q, rneg_q, div0_p_q, ovf_p_q;

    op_e              op_in;
    logic             sgn_in, a_neg, b_neg, div0_in, ovf_in;
    logic             accept, wr_res, is_mul;
    logic [WIDTH-1:0] res_fix;

    assign op_in   = op_e'(op);
    assign sgn_in  = is_signed_op(op_in);
    assign a_neg   = sgn_in & a[WIDTH-1];
    assign b_neg   = sgn_in & b[WIDTH-1];
    assign div0_in = (op_in != OP_MUL) && (b == '0);
    assign ovf_in  = sgn_in && (a == MIN_INT) && (b == '1);
    assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !abort;
    assign wr_res  = (state_q == S_FIXUP) && !abort;
    assign is_mul  = (op_q == OP_MUL);

    // Combinational step chain: UNROLL bits per RUN edge
    logic [WIDTH-1:0]  acc_c [UNROLL+1];
    logic [WIDTH-1:0]  sh_c  [UNROLL+1];
    logic [UNROLL-1:0] q_c;

    assign acc_c[0] = acc_q;
    assign sh_c[0]  = sh_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_mul (is_mul),
            .acc_i  (acc_c[k]),
            .bit_i  (sh_c[k][WIDTH-1]),
            .opnd_i (opnd_q),
            .acc_o  (acc_c[k+1]),
            .qbit_o (q_c[k])
        );
        assign sh_c[k+1] = {sh_c[k][WIDTH-2:0], q_c[k]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(N);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
            end
            S_FIXUP: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Sign post-conditioning; a zero divisor forces an all-ones quotient
    always_comb begin
        res_fix = acc_q;
        unique case (op_q)
            OP_DIV:  res_fix = div0_p_q ? '1 : magnitude(sh_q, qneg_q);
            OP_MOD:  res_fix = magnitude(acc_q, rneg_q);
            OP_DIVU: res_fix = div0_p_q ? '1 : sh_q;
            default: res_fix = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_FIXUP);
            done_q  <= (state_d == S_DONE);
            if (wr_res) begin
                result_q <= res_fix;
                div0_q   <= div0_p_q;
                ovf_q    <= ovf_p_q;
            end
        end
    end

    // Operand registers: MUL shifts the multiplier out of sh_q, divides shift the dividend
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op_in;
            acc_q    <= '0;
            sh_q     <= (op_in == OP_MUL) ? b : magnitude(a, a_neg);
            opnd_q   <= (op_in == OP_MUL) ? a : magnitude(b, b_neg);
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            div0_p_q <= div0_in;
            ovf_p_q  <= ovf_in;
        end else if (state_q == S_RUN) begin
            acc_q <= acc_c[UNROLL];
            sh_q  <= sh_c[UNROLL];
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign div0   = div0_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_beta_muldiv.sv
// Bench for beta_muldiv: directed vector table, randomized ops against an arithmetic
// reference model, and handshake corner sequences on UNROLL=1 and UNROLL=4 instances.
module tb_beta_muldiv;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_s   = 2'b00;
    logic [1:0]   start_s = 2'b00;
    logic [1:0]   abort_s = 2'b00;
    logic [1:0]   op_r    = 2'b00;
    logic [W-1:0] a_r     = '0;
    logic [W-1:0] b_r     = '0;
    logic [1:0]   busy_s, done_s, div0_s, ovf_s;
    logic [W-1:0] res_s [2];

    int n_cmp = 0;
    int n_bad = 0;

    beta_muldiv #(.WIDTH(W), .UNROLL(1)) dut1 (
        .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .op(op_r), .a(a_r), .b(b_r),
        .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0]), .div0(div0_s[0]), .ovf(ovf_s[0])
    );

    beta_muldiv #(.WIDTH(W), .UNROLL(4)) dut4 (
        .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .op(op_r), .a(a_r), .b(b_r),
        .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1]), .div0(div0_s[1]), .ovf(ovf_s[1])
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         d0;
        logic         ov;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? (W / 1 + 2) : (W / 4 + 2);
    endfunction

    // Reference: plain SystemVerilog arithmetic plus the documented special cases
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic d0, output logic ov);
        logic signed [W-1:0] sa, sb;
        logic                is_ovf;
        sa = a;
        sb = b;
        d0 = 1'b0;
        ov = 1'b0;
        is_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: r = a * b;
            2'd1: begin
                if (b == 0) begin r = '1; d0 = 1'b1; end
                else if (is_ovf) begin r = 32'h8000_0000; ov = 1'b1; end
                else r = sa / sb;
            end
            2'd2: begin
                if (b == 0) begin r = a; d0 = 1'b1; end
                else if (is_ovf) begin r = '0; ov = 1'b1; end
                else r = sa % sb;
            end
            default: begin
                if (b == 0) begin r = '1; d0 = 1'b1; end
                else r = a / b;
            end
        endcase
    endtask

    task automatic issue(input int u, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_r = op;
        a_r  = a;
        b_r  = b;
        start_s[u] = 1'b1;
        @(posedge clk);
        #1;
        start_s[u] = 1'b0;
    endtask

    // lat counts the start-sampling edge as edge 1
    task automatic wait_done(input int u, output int lat);
        lat = 1;
        while (lat <= 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_s[u]) break;
        end
    endtask

    task automatic no_done(input int u, input int cycles, output logic seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done_s[u]) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input int u, input string tag, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic ed0, input logic eov);
        int lat;
        issue(u, op, a, b);
        chk1({tag, " busy after start"}, busy_s[u], 1'b1);
        wait_done(u, lat);
        chk({tag, " latency"}, W'(lat), W'(lat_of(u)));
        chk1({tag, " busy in done cycle"}, busy_s[u], 1'b0);
        chk({tag, " result"}, res_s[u], er);
        chk1({tag, " div0"}, div0_s[u], ed0);
        chk1({tag, " ovf"}, ovf_s[u], eov);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er, prev;
        logic [1:0]   rop;
        logic         ed0, eov, seen;
        int           lat;

        vt[0]  = '{2'd0, 32'd7,          32'd6,          32'd42,         1'b0, 1'b0};
        vt[1]  = '{2'd0, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0, 1'b0};
        vt[2]  = '{2'd1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0};
        vt[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vt[4]  = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  1'b0, 1'b0};
        vt[5]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0};
        vt[6]  = '{2'd2, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0};
        vt[7]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1};
        vt[8]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1};
        vt[9]  = '{2'd3, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
        vt[10] = '{2'd1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 1'b0};
        vt[11] = '{2'd2, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0};
        vt[12] = '{2'd3, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  1'b0, 1'b0};
        vt[13] = '{2'd0, 32'h8000_0000,  32'd2,          32'd0,          1'b0, 1'b0};

        rst_s = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_s = 2'b00;
        for (int u = 0; u < 2; u++) begin
            chk1("reset busy", busy_s[u], 1'b0);
            chk1("reset done", done_s[u], 1'b0);
            chk("reset result", res_s[u], '0);
            chk1("reset div0", div0_s[u], 1'b0);
            chk1("reset ovf", ovf_s[u], 1'b0);
        end

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 14; i++) begin
                run_vec(u, $sformatf("vec%0d/u%0d", i, u), vt[i].op, vt[i].a, vt[i].b,
                        vt[i].res, vt[i].d0, vt[i].ov);
            end
        end

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 40; i++) begin
                rop = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0:       ra = 32'h8000_0000;
                    1:       ra = $urandom_range(0, 50);
                    2:       ra = -$urandom_range(1, 50);
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 4))
                    0:       rb = '0;
                    1:       rb = '1;
                    2:       rb = $urandom_range(1, 20);
                    3:       rb = -$urandom_range(1, 20);
                    default: rb = $urandom;
                endcase
                model(rop, ra, rb, er, ed0, eov);
                run_vec(u, $sformatf("rnd%0d/u%0d op%0d %h,%h", i, u, rop, ra, rb),
                        rop, ra, rb, er, ed0, eov);
            end
        end

        // Abort mid-RUN: no done, previous outputs kept, then a fresh op works
        prev = res_s[0];
        issue(0, 2'd0, 32'd3, 32'd5);
        repeat (8) begin @(posedge clk); #1; end
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        chk1("abort busy", busy_s[0], 1'b0);
        no_done(0, 40, seen);
        chk1("abort no done", seen, 1'b0);
        chk("abort result kept", res_s[0], prev);
        run_vec(0, "after abort DIV 100/7", 2'd1, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

        // Starts while busy are ignored and not queued
        issue(0, 2'd1, 32'd1000, 32'd3);
        lat = 1;
        while (lat <= 200) begin
            if (lat == 4 || lat == 19) begin
                op_r = 2'd0; a_r = 32'd9; b_r = 32'd9;
                start_s[0] = 1'b1;
            end
            @(posedge clk);
            #1;
            start_s[0] = 1'b0;
            lat++;
            if (done_s[0]) break;
        end
        chk("ignored start latency", W'(lat), W'(lat_of(0)));
        chk("ignored start result", res_s[0], 32'd333);
        no_done(0, 40, seen);
        chk1("ignored start not queued", seen, 1'b0);

        // Back-to-back: start held in the DONE cycle
        issue(0, 2'd0, 32'd7, 32'd6);
        wait_done(0, lat);
        chk("b2b first result", res_s[0], 32'd42);
        op_r = 2'd3; a_r = 32'd1000; b_r = 32'd10;
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        chk1("b2b done one cycle", done_s[0], 1'b0);
        chk1("b2b busy", busy_s[0], 1'b1);
        wait_done(0, lat);
        chk("b2b second latency", W'(lat), W'(lat_of(0)));
        chk("b2b second result", res_s[0], 32'd100);

        // Abort in the DONE cycle only ends the pulse
        issue(0, 2'd0, 32'd11, 32'd11);
        wait_done(0, lat);
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        chk1("abort in done: done", done_s[0], 1'b0);
        chk("abort in done: result", res_s[0], 32'd121);

        // Abort together with start drops the start
        op_r = 2'd0; a_r = 32'd2; b_r = 32'd2;
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        chk1("abort+start busy", busy_s[0], 1'b0);
        no_done(0, 40, seen);
        chk1("abort+start no done", seen, 1'b0);
        chk("abort+start result", res_s[0], 32'd121);

        // Reset mid-RUN on the UNROLL=4 instance clears all outputs
        run_vec(1, "u4 DIV 5/0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(1, 2'd0, 32'd3, 32'd3);
        repeat (3) begin @(posedge clk); #1; end
        rst_s[1] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[1] = 1'b0;
        chk1("midrun reset busy", busy_s[1], 1'b0);
        chk1("midrun reset done", done_s[1], 1'b0);
        chk("midrun reset result", res_s[1], '0);
        chk1("midrun reset div0", div0_s[1], 1'b0);
        chk1("midrun reset ovf", ovf_s[1], 1'b0);
        no_done(1, 20, seen);
        chk1("midrun reset no done", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
